// File: rtl/sram_bus_pkg.sv
// Shared encodings for the SRAM-like request/response bus: master IDs and access sizes.
package sram_bus_pkg;

    localparam logic SRAM_ID_INST = 1'b0;
    localparam logic SRAM_ID_DATA = 1'b1;

    localparam logic [1:0] SRAM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] SRAM_SIZE_HALF = 2'd1;
    localparam logic [1:0] SRAM_SIZE_WORD = 2'd2;

endpackage

// File: rtl/id_fifo.sv
// Small FIFO of master IDs for transactions accepted by the slave but not yet answered.
module id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A pop in the same cycle never makes room for a push: push looks at count only.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master (fetch/data) to one-slave SRAM bus arbiter with in-order response routing.
module sram_arbiter
    import sram_bus_pkg::*;
#(
    parameter int OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_req,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        proto_err
);

    logic lock_vld;
    logic lock_id;
    logic grant_id;
    logic grant_req;
    logic accept;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_head;
    logic pop;
    logic sel_data;

    // A request already shown to the slave keeps the grant until accepted.
    always_comb begin
        grant_id = SRAM_ID_INST;
        if (lock_vld)           grant_id = lock_id;
        else if (data_sram_req) grant_id = SRAM_ID_DATA;
    end

    assign sel_data  = (grant_id == SRAM_ID_DATA);
    assign grant_req = sel_data ? data_sram_req : inst_sram_req;
    assign mem_req   = resetn & grant_req & ~fifo_full;
    assign accept    = mem_req & mem_addr_ok;

    assign mem_wr    = sel_data & data_sram_wr;
    assign mem_size  = sel_data ? data_sram_size  : inst_sram_size;
    assign mem_wstrb = sel_data ? data_sram_wstrb : 4'h0;
    assign mem_addr  = sel_data ? data_sram_addr  : inst_sram_addr;
    assign mem_wdata = sel_data ? data_sram_wdata : 32'h0;

    assign inst_sram_addr_ok = accept & ~sel_data;
    assign data_sram_addr_ok = accept & sel_data;

    assign pop               = resetn & mem_data_ok & ~fifo_empty;
    assign inst_sram_data_ok = pop & (fifo_head == SRAM_ID_INST);
    assign data_sram_data_ok = pop & (fifo_head == SRAM_ID_DATA);
    assign inst_sram_rdata   = mem_rdata;
    assign data_sram_rdata   = mem_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_vld  <= 1'b0;
            lock_id   <= SRAM_ID_INST;
            proto_err <= 1'b0;
        end else begin
            if (accept) begin
                lock_vld <= 1'b0;
            end else if (mem_req) begin
                lock_vld <= 1'b1;
                lock_id  <= grant_id;
            end
            if (mem_data_ok && fifo_empty) proto_err <= 1'b1;
        end
    end

    id_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (1)
    ) u_id_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (accept),
        .push_data (grant_id),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

endmodule
